// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Reorders the bit-reversed output stream of fft_1k into natural order.
// Incoming samples are written into one of two banks at bit-reversed
// addresses. A full bank is read back at natural addresses 0..N-1 and streamed
// out through a 2-entry skid buffer under a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_start   pulse with sample 0 of an input frame
//   in_end     pulse with sample N-1 of an input frame
//   in_real    real word of the current input sample
//   in_img     imaginary word of the current input sample
//   out_ready  sink accepts the current output word
//   out_valid  output word valid
//   out_start  output word is natural-order sample 0
//   out_end    output word is natural-order sample N-1
//   out_real   reordered real word
//   out_img    reordered imaginary word
//   overflow   sticky: a frame was dropped because both banks were occupied
//   frame_err  sticky: a malformed frame was discarded
//
// Writer FSM
//   state  | meaning
//   W_IDLE | waiting for in_start
//   W_FILL | storing a frame into the write bank
//   W_DROP | discarding a frame that found no free bank
//
// Reader FSM
//   state   | meaning
//   R_IDLE  | waiting for the issue bank to become full (issues address 0)
//   R_DRAIN | issuing natural-order reads 1..N-1 as the skid buffer allows
// -----------------------------------------------------------------------------
module fft_bitrev_reorder #(
   parameter int LAYER = 10,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_start,
   input  logic             in_end,
   input  logic [WIDTH-1:0] in_real,
   input  logic [WIDTH-1:0] in_img,
   input  logic             out_ready,
   output logic             out_valid,
   output logic             out_start,
   output logic             out_end,
   output logic [WIDTH-1:0] out_real,
   output logic [WIDTH-1:0] out_img,
   output logic             overflow,
   output logic             frame_err
);

   localparam int N  = 1 << LAYER;
   localparam int DW = 2 * WIDTH;
   localparam logic [LAYER-1:0] LAST = LAYER'(N - 1);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DRAIN}        rd_state_t;

   function automatic logic [LAYER-1:0] bitrev(input logic [LAYER-1:0] a);
      logic [LAYER-1:0] r;
      for (int i = 0; i < LAYER; i++) r[i] = a[LAYER-1-i];
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Shared state
   // ---------------------------------------------------------------------------
   logic [DW-1:0]    mem [0:2*N-1];
   logic [DW-1:0]    mem_q;

   logic [1:0]       full;
   logic [1:0]       full_eff;
   logic [1:0]       set_mask;
   logic [1:0]       free_mask;

   // Writer
   wr_state_t        w_state, w_next;
   logic             wr_bank;
   logic [LAYER-1:0] wr_cnt, wr_cnt_nxt;
   logic [LAYER-1:0] wr_addr;
   logic             wr_en;
   logic             set_full, set_ovf, set_ferr;

   // Reader issue side
   rd_state_t        r_state, r_next;
   logic             iss_bank;
   logic [LAYER-1:0] rd_addr, rd_addr_cur;
   logic             rd_en;
   logic             space;
   logic [1:0]       occ;

   // Read pipeline stage (memory output) and skid buffer
   logic             rd_vld, rd_s, rd_e;
   logic             head_v, head_s, head_e;
   logic [DW-1:0]    head_d;
   logic             sk_v, sk_s, sk_e;
   logic [DW-1:0]    sk_d;
   logic             rd_bank;
   logic             pop, free;

   // A bank being released by the reader this cycle is already usable by the
   // writer in the same cycle.
   assign pop       = head_v & out_ready;
   assign free      = pop & head_e;
   assign free_mask = {rd_bank, ~rd_bank} & {2{free}};
   assign set_mask  = {wr_bank, ~wr_bank} & {2{set_full}};
   assign full_eff  = full & ~free_mask;

   // ---------------------------------------------------------------------------
   // Storage: one write port (writer), one registered read port (reader)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank, wr_addr}] <= {in_real, in_img};
      if (rd_en) mem_q <= mem[{iss_bank, rd_addr_cur}];
   end

   // ---------------------------------------------------------------------------
   // Writer FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state   <= W_IDLE;
         wr_cnt    <= '0;
         wr_bank   <= 1'b0;
         full      <= 2'b00;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         w_state <= w_next;
         wr_cnt  <= wr_cnt_nxt;
         full    <= full_eff | set_mask;
         if (set_full) wr_bank   <= ~wr_bank;
         if (set_ovf)  overflow  <= 1'b1;
         if (set_ferr) frame_err <= 1'b1;
      end
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE: begin
            if (in_start) w_next = full_eff[wr_bank] ? W_DROP : W_FILL;
         end
         W_DROP: begin
            if (in_start)    w_next = full_eff[wr_bank] ? W_DROP : W_FILL;
            else if (in_end) w_next = W_IDLE;
         end
         W_FILL: begin
            if (in_start)                       w_next = W_FILL;
            else if (in_end || wr_cnt == LAST)  w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_cnt_nxt = wr_cnt;
      set_full   = 1'b0;
      set_ovf    = 1'b0;
      set_ferr   = 1'b0;
      case (w_state)
         W_IDLE, W_DROP: begin
            if (in_start) begin
               if (!full_eff[wr_bank]) begin
                  wr_en      = 1'b1;
                  wr_cnt_nxt = LAYER'(1);
               end else begin
                  set_ovf = 1'b1;
               end
            end
         end
         W_FILL: begin
            wr_en = 1'b1;
            if (in_start) begin
               // restart on the same bank; sample 0 lands at address 0
               wr_cnt_nxt = LAYER'(1);
               set_ferr   = 1'b1;
            end else begin
               wr_addr    = bitrev(wr_cnt);
               wr_cnt_nxt = wr_cnt + LAYER'(1);
               if (in_end) begin
                  if (wr_cnt == LAST) set_full = 1'b1;
                  else                set_ferr = 1'b1;
               end else if (wr_cnt == LAST) begin
                  // the frame ran past N samples without an end marker
                  set_ferr = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Reader issue FSM
   // ---------------------------------------------------------------------------
   // Words in flight (memory stage) plus words held in the skid buffer must
   // stay within two; a pop this cycle makes room for one more read.
   assign occ   = 2'(head_v) + 2'(sk_v) + 2'(rd_vld);
   assign space = (occ - 2'(pop)) < 2'd2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= R_IDLE;
         rd_addr  <= '0;
         iss_bank <= 1'b0;
         rd_vld   <= 1'b0;
         rd_s     <= 1'b0;
         rd_e     <= 1'b0;
      end else begin
         r_state <= r_next;
         rd_vld  <= rd_en;
         rd_s    <= rd_en && (rd_addr_cur == '0);
         rd_e    <= rd_en && (rd_addr_cur == LAST);
         if (rd_en) begin
            rd_addr <= rd_addr_cur + LAYER'(1);
            // The issue pointer moves to the other bank as soon as the last
            // read is issued so the next frame follows without a bubble.
            if (rd_addr_cur == LAST) iss_bank <= ~iss_bank;
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (full[iss_bank] && space)   r_next = R_DRAIN;
         R_DRAIN: if (space && rd_addr == LAST)  r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_en       = 1'b0;
      rd_addr_cur = rd_addr;
      case (r_state)
         R_IDLE: begin
            rd_en       = full[iss_bank] & space;
            rd_addr_cur = '0;
         end
         R_DRAIN: rd_en = space;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Skid buffer and bank release
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_v  <= 1'b0;
         head_s  <= 1'b0;
         head_e  <= 1'b0;
         head_d  <= '0;
         sk_v    <= 1'b0;
         sk_s    <= 1'b0;
         sk_e    <= 1'b0;
         sk_d    <= '0;
         rd_bank <= 1'b0;
      end else begin
         if (free) rd_bank <= ~rd_bank;
         if (pop && sk_v) begin
            head_v <= 1'b1;
            head_s <= sk_s;
            head_e <= sk_e;
            head_d <= sk_d;
            sk_v   <= rd_vld;
            if (rd_vld) begin
               sk_s <= rd_s;
               sk_e <= rd_e;
               sk_d <= mem_q;
            end
         end else if (pop || !head_v) begin
            head_v <= rd_vld;
            if (rd_vld) begin
               head_s <= rd_s;
               head_e <= rd_e;
               head_d <= mem_q;
            end
         end else if (rd_vld) begin
            sk_v <= 1'b1;
            sk_s <= rd_s;
            sk_e <= rd_e;
            sk_d <= mem_q;
         end
      end
   end

   assign out_valid = head_v;
   assign out_start = head_v & head_s;
   assign out_end   = head_v & head_e;
   assign out_real  = head_d[DW-1:WIDTH];
   assign out_img   = head_d[WIDTH-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

   localparam int L10 = 10;
   localparam int N10 = 1024;
   localparam int L3  = 3;
   localparam int N3  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT with LAYER=10
   logic        s10 = 0, e10 = 0, rdy10 = 1;
   logic [31:0] re10 = 0, im10 = 0;
   logic        ov10, os10, oe10, ovf10, fe10;
   logic [31:0] or10, oi10;

   // DUT with LAYER=3
   logic        s3 = 0, e3 = 0, rdy3 = 1;
   logic [31:0] re3 = 0, im3 = 0;
   logic        ov3, os3, oe3, ovf3, fe3;
   logic [31:0] or3, oi3;

   fft_bitrev_reorder #(.LAYER(L10), .WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_start(s10), .in_end(e10),
      .in_real(re10), .in_img(im10), .out_ready(rdy10),
      .out_valid(ov10), .out_start(os10), .out_end(oe10),
      .out_real(or10), .out_img(oi10), .overflow(ovf10), .frame_err(fe10));

   fft_bitrev_reorder #(.LAYER(L3), .WIDTH(32)) dut3 (
      .clk(clk), .rst(rst), .in_start(s3), .in_end(e3),
      .in_real(re3), .in_img(im3), .out_ready(rdy3),
      .out_valid(ov3), .out_start(os3), .out_end(oe3),
      .out_real(or3), .out_img(oi3), .overflow(ovf3), .frame_err(fe3));

   int checks = 0;
   int errors = 0;

   typedef logic [65:0] word_t;   // {start, end, real, img}
   word_t q10[$];
   word_t q3[$];
   int    st10[$];
   int    en10[$];
   int    end_cyc10;

   logic [31:0] sre [0:N10-1];
   logic [31:0] sim [0:N10-1];
   logic [31:0] sre3[0:N3-1];
   logic [31:0] sim3[0:N3-1];
   int          lit[8];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // index with its bits in reverse order, computed digit by digit
   function automatic int brev(input int x, input int nb);
      int r = 0;
      int v = x;
      for (int i = 0; i < nb; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         s10 = 0; e10 = 0; s3 = 0; e3 = 0;
      end
   endtask

   task automatic send10(input int len, input bit rnd, input bit push);
      for (int k = 0; k < len; k++) begin
         sre[k] = rnd ? $urandom : 32'(k);
         sim[k] = rnd ? $urandom : ~32'(k);
         @(posedge clk); #1;
         s10 = (k == 0); e10 = (k == len - 1);
         re10 = sre[k]; im10 = sim[k];
      end
      end_cyc10 = cyc;
      if (push)
         for (int n = 0; n < N10; n++) begin
            int k2 = brev(n, L10);
            q10.push_back({n == 0, n == N10 - 1, sre[k2], sim[k2]});
         end
   endtask

   task automatic send3(input int len, input bit rnd, input bit has_end, input bit push);
      for (int k = 0; k < len; k++) begin
         sre3[k] = rnd ? $urandom : 32'(k);
         sim3[k] = rnd ? $urandom : ~32'(k);
         @(posedge clk); #1;
         s3 = (k == 0); e3 = has_end && (k == len - 1);
         re3 = sre3[k]; im3 = sim3[k];
      end
      if (push)
         for (int n = 0; n < N3; n++) begin
            int k2 = brev(n, L3);
            q3.push_back({n == 0, n == N3 - 1, sre3[k2], sim3[k2]});
         end
   endtask

   task automatic wait10(input int maxc, input string tag);
      cycles(1);
      for (int i = 0; i < maxc && !(q10.size() == 0 && !ov10); i++) cycles(1);
      chk(tag, q10.size(), 0);
   endtask

   task automatic wait3(input int maxc, input string tag);
      cycles(1);
      for (int i = 0; i < maxc && !(q3.size() == 0 && !ov3); i++) cycles(1);
      chk(tag, q3.size(), 0);
   endtask

   // Output monitors: every accepted word is checked against the model queue,
   // and a stalled word must not change until it is taken.
   logic        hold10 = 0, hold3 = 0;
   logic [66:0] hv10, hv3;

   always @(negedge clk) begin
      if (!rst) hold10 = 0;
      else begin
         if (hold10) chk("hold10", {ov10, os10, oe10, or10, oi10}, hv10);
         if (ov10 && rdy10) begin
            chk("word_avail10", q10.size() != 0, 1'b1);
            if (q10.size() != 0) chk("word10", {os10, oe10, or10, oi10}, q10.pop_front());
            if (os10) st10.push_back(cyc);
            if (oe10) en10.push_back(cyc);
         end
         hold10 = ov10 && !rdy10;
         hv10   = {ov10, os10, oe10, or10, oi10};
      end
   end

   always @(negedge clk) begin
      if (!rst) hold3 = 0;
      else begin
         if (hold3) chk("hold3", {ov3, os3, oe3, or3, oi3}, hv3);
         if (ov3 && rdy3) begin
            chk("word_avail3", q3.size() != 0, 1'b1);
            if (q3.size() != 0) chk("word3", {os3, oe3, or3, oi3}, q3.pop_front());
         end
         hold3 = ov3 && !rdy3;
         hv3   = {ov3, os3, oe3, or3, oi3};
      end
   end

   initial begin
      lit = '{0, 4, 2, 6, 1, 5, 3, 7};
      repeat (3) @(posedge clk);
      #1;
      chk("reset10", {ov10, os10, oe10, or10, oi10, ovf10, fe10}, 0);
      chk("reset3",  {ov3, os3, oe3, or3, oi3, ovf3, fe3}, 0);
      @(posedge clk); #1;
      rst = 1;
      cycles(2);

      // single frame, real=k / img=~k
      st10.delete(); en10.delete();
      send10(N10, 0, 1);
      wait10(1200, "drain_single");
      chk("latency_single", st10[0] - end_cyc10, 3);
      chk("frames_single", en10.size(), 1);

      // back-to-back frames
      st10.delete(); en10.delete();
      send10(N10, 1, 1);
      send10(N10, 1, 1);
      wait10(2300, "drain_b2b");
      chk("b2b_span", en10[1] - st10[0], 2047);
      chk("b2b_ovf", ovf10, 0);

      // three frames into a stalled sink: third is dropped
      rdy10 = 0;
      send10(N10, 1, 1);
      send10(N10, 1, 1);
      chk("ovf_before_third", ovf10, 0);
      send10(N10, 1, 0);
      cycles(20);
      chk("stalled_pending", q10.size(), 2 * N10);
      chk("ovf_third", ovf10, 1);
      rdy10 = 1;
      wait10(2300, "drain_stalled");
      chk("ferr_after_drop", fe10, 0);

      // short frame then a good one
      send10(501, 1, 0);
      cycles(5);
      chk("ferr_short", fe10, 1);
      send10(N10, 1, 1);
      wait10(1200, "drain_after_short");

      // LAYER=3 with random sink stalls: natural order of index data
      for (int n = 0; n < N3; n++)
         q3.push_back({n == 0, n == N3 - 1, 32'(lit[n]), ~32'(lit[n])});
      fork
         send3(N3, 0, 1, 0);
         begin
            for (int i = 0; i < 60; i++) begin
               @(posedge clk); #1;
               rdy3 = 1'($urandom_range(0, 1));
            end
            rdy3 = 1;
         end
      join
      wait3(100, "drain_stall3");
      fork
         send3(N3, 1, 1, 1);
         begin
            for (int i = 0; i < 60; i++) begin
               @(posedge clk); #1;
               rdy3 = 1'($urandom_range(0, 1));
            end
            rdy3 = 1;
         end
      join
      wait3(100, "drain_rand3");
      chk("ferr3_clean", fe3, 0);

      // frame runs past N without in_end
      send3(N3, 1, 0, 0);
      wait3(30, "drain_overrun3");
      chk("ferr_overrun3", fe3, 1);

      // in_start during a fill restarts the frame
      send3(3, 1, 0, 0);
      send3(N3, 1, 1, 1);
      wait3(30, "drain_restart3");
      chk("ovf3_clean", ovf3, 0);

      // reset in the middle of a drain
      send10(N10, 1, 1);
      cycles(50);
      chk("mid_drain_valid", ov10, 1);
      rst = 0;
      #1;
      chk("rst_mid10", {ov10, os10, oe10, or10, oi10, ovf10, fe10}, 0);
      chk("rst_mid3",  {ov3, os3, oe3, or3, oi3, ovf3, fe3}, 0);
      q10.delete();
      q3.delete();
      cycles(3);
      rst = 1;
      cycles(2);
      send10(N10, 1, 1);
      wait10(1200, "drain_after_rst");
      chk("flags_after_rst10", {ovf10, fe10}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
